sensor_input_conditioner: RTL and testbench
===========================================

// Module: sensor_input_conditioner
// PURPOSE
//  N-channel conditioner between the raw pad sensors / controller buttons and the processor and VGA.
//  Replaces the hard-wired per-bit NOT gates with four stages:
//   - per-channel polarity inversion;
//   - a synchronizer;
//   - a debouncer;
//   - an edge detector.
//  Also provides sticky per-channel event flags that the processor clears with a write-1-to-clear mask.
// PARAMETERS
//  NUM_CH          24        number of input channels (1..32)
//  SYNC_STAGES     2         synchronizer flops per channel (>=2)
//  DEBOUNCE_CYCLES 50000     consecutive cycles a new level must hold before acceptance (>=1)
//  INVERT_MASK     {NUM_CH{1'b0}}  bit=1 -> channel is active-low, inverted before sync
// PORTS
//  clock          in   1       system clock
//  reset          in   1       asynchronous, active-high reset
//  raw_in         in   NUM_CH  unsynchronized pad/button inputs
//  clear_events   in   NUM_CH  write-1-to-clear for event_latched, one-cycle strobe
//  level_out      out  NUM_CH  debounced, polarity-corrected level
//  rise_pulse     out  NUM_CH  1-cycle pulse on accepted 0->1 of level_out
//  fall_pulse     out  NUM_CH  1-cycle pulse on accepted 1->0 of level_out
//  event_latched  out  NUM_CH  sticky: set by rise_pulse, cleared by clear_events
//  any_event      out  1       OR-reduction of event_latched, registered
//  event_count    out  8*NUM_CH  per-channel rise counters (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all sync flops, stable levels, debounce counters, pulses, latches, any_event and event_count are 0.
//  - Reset behaviour:
//    - Asserting reset mid-debounce discards the partial count.
//    - No pulse is emitted on reset entry or release.
//  - Path: cond = raw_in ^ INVERT_MASK feeds the SYNC_STAGES-flop chain; sync_q is the last stage.
//  - Debounce, per channel:
//    - Counter width is $clog2(DEBOUNCE_CYCLES+1).
//    - If sync_q == stable, the counter is cleared to 0.
//    - Else the counter increments.
//    - When the counter == DEBOUNCE_CYCLES-1 while sync_q != stable, the next cycle sets stable <= sync_q and clears the counter.
//    - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
//    - The counter never wraps.
//  - Latency: a clean raw_in step changes level_out exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles later.
//  - Edge pulses:
//    - rise_pulse/fall_pulse are registered and high in the same cycle level_out first shows the new value.
//    - Each is high for exactly 1 cycle.
//    - rise_pulse and fall_pulse are never both high on one channel.
//  - event_latched[i]:
//    - Set when rise_pulse[i].
//    - Cleared when clear_events[i].
//    - Simultaneous set and clear: set wins, so the event is never lost.
//    - Clearing a channel leaves the other channels untouched.
//  - any_event updates 1 cycle after event_latched.
//  - Input held active through reset release: a rise is emitted after the normal latency.
//  - DEBOUNCE_CYCLES==0, NUM_CH==0 or NUM_CH>32 is an elaboration error.
// CONFIGURATION
//  - Macro SENSOR_EVENT_COUNT_EN.
//  - Defined:
//    - event_count[8i+7:8i] increments on rise_pulse[i] and saturates at 255.
//    - It is cleared by clear_events[i].
//    - Simultaneous clear and rise loads 1.
//  - Undefined: event_count is driven to all zeros and no counter flops are built; the port list is unchanged.
// STRUCTURE
//  - Package sensor_cond_pkg:
//    - MAX_CH=32;
//    - EVT_CNT_W=8;
//    - function cnt_width(n) returning $clog2(n+1).
//  - Sub-module debounce_channel: one channel's sync chain, counter, stable level and edge pulses.
//    - Instantiated NUM_CH times with a generate loop.
//  - Top level: holds inversion, event latches, any_event and the optional counters.
// TESTING  (bench: NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INVERT_MASK=4'b1000)
//  1 Reset: reset=1 with raw_in=4'h7 -> all outputs 0; release -> level_out=4'h7 at cycle 6, rise_pulse=4'h7 for 1 cycle.
//  2 Glitch: raw_in[0] high for 3 cycles then low -> level_out[0], rise_pulse[0] stay 0.
//  3 Step/latency: raw_in[1] 0->1 held -> level_out[1]=1 exactly 6 cycles later; rise once; 1->0 gives fall_pulse[1] 6 cycles later.
//  4 Inversion: raw_in[3] 1->0 -> level_out[3] 0->1 after 6 cycles; event_latched[3]=1, any_event=1 one cycle later.
//  5 Clear race: clear_events[2]=1 in the same cycle as rise_pulse[2] -> event_latched[2] stays 1; clear next cycle -> 0, others unchanged.
//  6 SENSOR_EVENT_COUNT_EN: 300 clean rises on ch0 -> event_count[7:0]=255; clear_events[0] -> 0; clear with a rise -> 1.

Source files
------------

// File: rtl/sensor_input_conditioner_pkg.sv
// Shared constants and helpers for the sensor input conditioner.
package sensor_cond_pkg;

  localparam int MAX_CH    = 32;
  localparam int EVT_CNT_W = 8;

  // Bits needed to hold any value from 0 up to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sensor_input_conditioner_if.sv
// Channel bundle between the pads/processor side and the sensor input conditioner.
interface sensor_input_conditioner_if #(
  parameter int NUM_CH = 24
);

  logic [NUM_CH-1:0]                             raw_in;
  logic [NUM_CH-1:0]                             clear_events;
  logic [NUM_CH-1:0]                             level_out;
  logic [NUM_CH-1:0]                             rise_pulse;
  logic [NUM_CH-1:0]                             fall_pulse;
  logic [NUM_CH-1:0]                             event_latched;
  logic                                          any_event;
  logic [sensor_cond_pkg::EVT_CNT_W*NUM_CH-1:0]  event_count;

  modport master (
    output raw_in, clear_events,
    input  level_out, rise_pulse, fall_pulse, event_latched, any_event, event_count
  );

  modport slave (
    input  raw_in, clear_events,
    output level_out, rise_pulse, fall_pulse, event_latched, any_event, event_count
  );

endinterface

// File: rtl/sensor_input_conditioner_debounce_channel.sv
// One channel: synchronizer chain, debounce counter, accepted level and edge pulses.
module debounce_channel
  import sensor_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic cond_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_q;
  logic [CW-1:0]          count;
  logic                   accept;

  assign sync_q = sync_chain[SYNC_STAGES-1];
  assign accept = (sync_q != level) && (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_chain <= '0;
    else       sync_chain <= {sync_chain[SYNC_STAGES-2:0], cond_in};
  end

  // The counter only runs while the synchronized input disagrees with the
  // accepted level, so it tops out at LAST and can never wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= accept & sync_q;
      fall <= accept & ~sync_q;
      if (sync_q == level) begin
        count <= '0;
      end else if (accept) begin
        level <= sync_q;
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sensor_input_conditioner.sv
// Sensor/button input conditioner: polarity fix, per-channel debounce, sticky events.
// Define SENSOR_EVENT_COUNT_EN to build the per-channel saturating rise counters.
module sensor_input_conditioner
  import sensor_cond_pkg::*;
#(
  parameter int                NUM_CH          = 24,
  parameter int                SYNC_STAGES     = 2,
  parameter int                DEBOUNCE_CYCLES = 50000,
  parameter logic [NUM_CH-1:0] INVERT_MASK     = '0
) (
  input logic                       clock,
  input logic                       reset,
  sensor_input_conditioner_if.slave bus
);

  logic [NUM_CH-1:0] cond;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] latched;
  logic              any_q;

  if (NUM_CH < 1 || NUM_CH > MAX_CH || DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_cfg
    $fatal(1, "sensor_input_conditioner: illegal NUM_CH, SYNC_STAGES or DEBOUNCE_CYCLES");
  end

  // Active-low channels are flipped before synchronizing so everything downstream is active-high.
  assign cond = bus.raw_in ^ INVERT_MASK;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .cond_in (cond[i]),
      .level   (level[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  // A rise arriving together with its clear still sets the flag, so no event is lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) latched <= '0;
    else       latched <= (latched & ~bus.clear_events) | rise;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) any_q <= 1'b0;
    else       any_q <= |latched;
  end

`ifdef SENSOR_EVENT_COUNT_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    logic [EVT_CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
      if (reset)                                 cnt <= '0;
      else if (rise[i] && bus.clear_events[i])   cnt <= EVT_CNT_W'(1);
      else if (bus.clear_events[i])              cnt <= '0;
      else if (rise[i] && (cnt != '1))           cnt <= cnt + EVT_CNT_W'(1);
    end

    assign bus.event_count[i*EVT_CNT_W +: EVT_CNT_W] = cnt;
  end
`else
  assign bus.event_count = '0;
`endif

  assign bus.level_out     = level;
  assign bus.rise_pulse    = rise;
  assign bus.fall_pulse    = fall;
  assign bus.event_latched = latched;
  assign bus.any_event     = any_q;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Scoreboard bench for sensor_input_conditioner: window-based reference model plus directed checks.
module tb_sensor_input_conditioner;

  localparam int         NUM_CH          = 4;
  localparam int         SYNC_STAGES     = 2;
  localparam int         DEBOUNCE_CYCLES = 4;
  localparam logic [3:0] INVERT_MASK     = 4'b1000;

  typedef struct packed {
    logic [3:0]  level;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [3:0]  latched;
    logic        any;
    logic [31:0] count;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exp_t       exp_q[$];
  logic [3:0] pipe[$];
  logic [3:0] win[$];
  logic [3:0] m_level, m_rise, m_fall, m_latched;
  logic       m_any;
  int         m_cnt[NUM_CH];

  always #5 clock = ~clock;

  sensor_input_conditioner_if #(.NUM_CH(NUM_CH)) bus ();

  sensor_input_conditioner #(
    .NUM_CH          (NUM_CH),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .INVERT_MASK     (INVERT_MASK)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    repeat (SYNC_STAGES) pipe.push_back(4'h0);
    win.delete();
    m_level = '0; m_rise = '0; m_fall = '0; m_latched = '0; m_any = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) m_cnt[ch] = 0;
  endtask

  // Level flips once the last DEBOUNCE_CYCLES synchronized samples all disagree with it.
  task automatic model_edge(input logic [3:0] cond, input logic [3:0] clr);
    logic [3:0] sample, nl, nlat;
    logic       nany;
    bit         all_diff;
    pipe.push_back(cond);
    sample = pipe.pop_front();
    win.push_back(sample);
    if (win.size() > DEBOUNCE_CYCLES) void'(win.pop_front());
    nl = m_level;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (win.size() == DEBOUNCE_CYCLES) begin
        all_diff = 1'b1;
        foreach (win[j]) if (win[j][ch] == m_level[ch]) all_diff = 1'b0;
        if (all_diff) nl[ch] = ~m_level[ch];
      end
    end
    nlat = (m_latched & ~clr) | m_rise;
    nany = |m_latched;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (m_rise[ch])     m_cnt[ch] = clr[ch] ? 1 : ((m_cnt[ch] < 255) ? m_cnt[ch] + 1 : 255);
      else if (clr[ch])   m_cnt[ch] = 0;
    end
    m_rise    = nl & ~m_level;
    m_fall    = ~nl & m_level;
    m_level   = nl;
    m_latched = nlat;
    m_any     = nany;
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.level   = m_level;
    e.rise    = m_rise;
    e.fall    = m_fall;
    e.latched = m_latched;
    e.any     = m_any;
    e.count   = '0;
`ifdef SENSOR_EVENT_COUNT_EN
    for (int ch = 0; ch < NUM_CH; ch++) e.count[ch*8 +: 8] = 8'(m_cnt[ch]);
`endif
    return e;
  endfunction

  task automatic apply_stimulus(input logic [3:0] raw, input logic [3:0] clr, input logic rst);
    @(negedge clock);
    bus.raw_in       = raw;
    bus.clear_events = clr;
    reset            = rst;
    if (rst) model_reset();
    else     model_edge(raw ^ INVERT_MASK, clr);
    exp_q.push_back(model_snapshot());
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  // Monitor: one expected record per clock edge, compared just after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("sb_level",   32'(bus.level_out),     32'(e.level));
        check_output("sb_rise",    32'(bus.rise_pulse),    32'(e.rise));
        check_output("sb_fall",    32'(bus.fall_pulse),    32'(e.fall));
        check_output("sb_latched", 32'(bus.event_latched), 32'(e.latched));
        check_output("sb_any",     32'(bus.any_event),     32'(e.any));
        check_output("sb_count",   bus.event_count,        e.count);
        check_output("sb_rise_fall_overlap", 32'(bus.rise_pulse & bus.fall_pulse), 32'h0);
      end
    end
  end

  initial begin
    int         first;
    int         n_rise;
    int         hold;
    logic [3:0] raw, clr;
    logic [7:0] exp_sat, exp_one;
`ifdef SENSOR_EVENT_COUNT_EN
    exp_sat = 8'd255;
    exp_one = 8'd1;
`else
    exp_sat = 8'd0;
    exp_one = 8'd0;
`endif
    bus.raw_in       = 4'hF;
    bus.clear_events = 4'h0;
    reset            = 1'b1;
    model_reset();

    // Reset with channels 0..2 active (raw F, channel 3 active-low so inactive).
    repeat (3) apply_stimulus(4'hF, 4'h0, 1'b1);
    settle();
    check_output("reset_level",   32'(bus.level_out),     32'h0);
    check_output("reset_rise",    32'(bus.rise_pulse),    32'h0);
    check_output("reset_latched", 32'(bus.event_latched), 32'h0);
    check_output("reset_any",     32'(bus.any_event),     32'h0);
    check_output("reset_count",   bus.event_count,        32'h0);
    for (int k = 1; k <= 8; k++) begin
      apply_stimulus(4'hF, 4'h0, 1'b0);
      settle();
      if (k == 5) check_output("release_level_c5", 32'(bus.level_out), 32'h0);
      if (k == 6) begin
        check_output("release_level_c6", 32'(bus.level_out),  32'h7);
        check_output("release_rise_c6",  32'(bus.rise_pulse), 32'h7);
      end
      if (k == 7) check_output("release_rise_c7", 32'(bus.rise_pulse), 32'h0);
    end

    // Glitch on channel 0 shorter than the debounce window.
    repeat (10) apply_stimulus(4'h8, 4'h0, 1'b0);
    apply_stimulus(4'h8, 4'hF, 1'b0);
    repeat (3) apply_stimulus(4'h8, 4'h0, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      apply_stimulus((k <= 3) ? 4'h9 : 4'h8, 4'h0, 1'b0);
      settle();
      check_output("glitch_level0", 32'(bus.level_out[0]),  32'h0);
      check_output("glitch_rise0",  32'(bus.rise_pulse[0]), 32'h0);
    end

    // Step latency on channel 1, both directions.
    first = 0; n_rise = 0;
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(4'hA, 4'h0, 1'b0);
      settle();
      if (first == 0 && bus.level_out[1]) first = k;
      n_rise += int'(bus.rise_pulse[1]);
    end
    check_output("step_rise_latency", 32'(first),  32'd6);
    check_output("step_rise_count",   32'(n_rise), 32'd1);
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(4'h8, 4'h0, 1'b0);
      settle();
      if (first == 0 && bus.fall_pulse[1]) first = k;
    end
    check_output("step_fall_latency", 32'(first), 32'd6);

    // Active-low channel 3: clear all flags, then drive its pad low.
    apply_stimulus(4'h8, 4'hF, 1'b0);
    repeat (2) apply_stimulus(4'h8, 4'h0, 1'b0);
    settle();
    check_output("cleared_latched", 32'(bus.event_latched), 32'h0);
    check_output("cleared_any",     32'(bus.any_event),     32'h0);
    for (int k = 1; k <= 8; k++) begin
      apply_stimulus(4'h0, 4'h0, 1'b0);
      settle();
      if (k == 6) check_output("invert_rise3", 32'(bus.rise_pulse), 32'h8);
      if (k == 7) begin
        check_output("invert_latched", 32'(bus.event_latched), 32'h8);
        check_output("invert_any_c7",  32'(bus.any_event),     32'h0);
      end
      if (k == 8) check_output("invert_any_c8", 32'(bus.any_event), 32'h1);
    end

    // Clear of channel 2 colliding with its rise, then a plain clear.
    for (int k = 1; k <= 9; k++) begin
      apply_stimulus(4'h4, (k == 7 || k == 8) ? 4'h4 : 4'h0, 1'b0);
      settle();
      if (k == 6) check_output("race_rise2",     32'(bus.rise_pulse),    32'h4);
      if (k == 7) check_output("race_set_wins",  32'(bus.event_latched), 32'hC);
      if (k == 8) check_output("race_clear",     32'(bus.event_latched), 32'h8);
    end

    // 300 clean rises on channel 0, then clear, then clear together with a rise.
    for (int r = 0; r < 300; r++) begin
      repeat (5) apply_stimulus(4'h5, 4'h0, 1'b0);
      repeat (5) apply_stimulus(4'h4, 4'h0, 1'b0);
    end
    repeat (6) apply_stimulus(4'h4, 4'h0, 1'b0);
    settle();
    check_output("count_saturated", 32'(bus.event_count[7:0]), 32'(exp_sat));
    apply_stimulus(4'h4, 4'h1, 1'b0);
    settle();
    check_output("count_cleared", 32'(bus.event_count[7:0]), 32'h0);
    for (int k = 1; k <= 8; k++) begin
      apply_stimulus(4'h5, (k == 7) ? 4'h1 : 4'h0, 1'b0);
      settle();
      if (k == 7) check_output("count_clear_with_rise", 32'(bus.event_count[7:0]), 32'(exp_one));
    end

    // Reset mid-debounce with channels 2 and 3 held active through release.
    repeat (2) apply_stimulus(4'h4, 4'h0, 1'b0);
    repeat (2) apply_stimulus(4'h4, 4'h0, 1'b1);
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(4'h4, 4'h0, 1'b0);
      settle();
      if (first == 0 && bus.rise_pulse != 4'h0) begin
        first = k;
        check_output("held_reset_rise_mask", 32'(bus.rise_pulse), 32'hC);
      end
    end
    check_output("held_reset_latency", 32'(first), 32'd6);

    // Random traffic with occasional clears and resets.
    for (int n = 0; n < 250; n++) begin
      raw  = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) begin
        clr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        apply_stimulus(raw, clr, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      end
    end
    repeat (3) apply_stimulus(raw, 4'h0, 1'b0);

    repeat (3) @(posedge clock);
    #2;
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
